// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a sequenced clear engine.
// Entry 0 reads as zero. Writes from higher-index ports override lower ones on
// address collision. Read outputs are registered and hold while re is low.
// The array has no per-entry reset so it can map onto RAM; a counter-driven
// clear zeroes entries 1..2^ADDR_W-1 after reset or when clr_i is pulsed.
// Optional feature macro: REGS_BYPASS_EN (same-edge write-to-read forwarding).
//
// Handshake: there is no valid/ready pairing on the data ports. ready_o is a
// status level: while it is low every write is dropped and every read returns
// zero; while it is high each port acts on its enable at every rising edge.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  output logic                       ready_o,
  output logic                       state_o,
  input  logic [NUM_WR-1:0]          we_i,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wdata_i,
  input  logic [NUM_RD-1:0]          re_i,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_WR-1:0]        wen;
  logic                     clear_we;

  // Current value seen by a read of address ra: array contents, optionally
  // overridden by a same-edge write (highest-index port wins).
  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = mem_q[ra];
`ifdef REGS_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++) begin
      if (wen[w] && (waddr_i[w*ADDR_W +: ADDR_W] == ra)) begin
        val = wdata_i[w*DATA_W +: DATA_W];
      end
    end
`endif
    return val;
  endfunction

  // Next state and clear counter: clr restarts the sweep from entry 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_i) begin
          cnt_d = CNT_FIRST;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_READY;
        end
      end
      default: begin
        if (clr_i) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_FIRST;
        end
      end
    endcase
  end

  // State and counter registers, asynchronously forced into a fresh clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= CNT_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Effective write enables: only in READY, not on a clr edge, never entry 0.
  always_comb begin
    clear_we = (state_q == S_CLEAR) && !clr_i;
    wen      = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wen[i] = (state_q == S_READY) && !clr_i && we_i[i] &&
               (waddr_i[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Array writes: clear sweep or port writes; later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[cnt_q] <= '0;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen[i]) begin
        mem_q[waddr_i[i*ADDR_W +: ADDR_W]] <= wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read-port next values: zero while clearing or for address 0, hold when idle.
  always_comb begin
    rdata_d = rdata_q;
    for (int r = 0; r < NUM_RD; r++) begin
      if (state_q == S_CLEAR) begin
        rdata_d[r*DATA_W +: DATA_W] = '0;
      end else if (raddr_i[r*ADDR_W +: ADDR_W] == '0) begin
        rdata_d[r*DATA_W +: DATA_W] = '0;
      end else if (re_i[r]) begin
        rdata_d[r*DATA_W +: DATA_W] = read_value(raddr_i[r*ADDR_W +: ADDR_W]);
      end
    end
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign ready_o = (state_q == S_READY);
  assign state_o = state_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp at default parameters (32-bit, 32 entries, 2R/2W).
// Builds with or without REGS_BYPASS_EN; same-edge expectations follow the macro.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        ready;
  logic        state;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef REGS_BYPASS_EN
  localparam logic [31:0] SAME7  = 32'h0000_000B;
  localparam logic [31:0] SAME12 = 32'h0000_3434;
`else
  localparam logic [31:0] SAME7  = 32'h0000_000A;
  localparam logic [31:0] SAME12 = 32'h0000_0000;
`endif

  regfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .ready_o (ready),
    .state_o (state),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [31:0] exp0, exp1;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] r, input logic [4:0] b0, input logic [4:0] b1,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.re = r; v.ra0 = b0; v.ra1 = b1; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // One rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we = 2'b00; waddr = '0; wdata = '0; re = 2'b00; raddr = '0;
  endtask

  task automatic drive_write(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
    we = w; waddr = {a1, a0}; wdata = {d1, d0};
  endtask

  task automatic drive_read(input logic [1:0] r, input logic [4:0] b0, input logic [4:0] b1);
    re = r; raddr = {b1, b0};
  endtask

  // Count the 31 clear edges, checking ready and zeroed reads on each
  task automatic clear_sweep(input string tag);
    for (int e = 1; e <= 31; e++) begin
      step();
      check($sformatf("%s ready e%0d", tag, e), {31'd0, ready}, {31'd0, (e == 31)});
      check($sformatf("%s rdata0 e%0d", tag, e), rdata[31:0], 32'h0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Vector table
    //            we     wa0 wa1 wd0           wd1           re     ra0 ra1 exp0          exp1
    tbl[0]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b11,  9, 31, 32'h0,        32'h0);
    tbl[1]  = mk(2'b11,  5,  5, 32'h1111_1111, 32'h2222_2222, 2'b00, 0,  0, 32'h0,        32'h0);
    tbl[2]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b11,  5,  5, 32'h2222_2222, 32'h2222_2222);
    tbl[3]  = mk(2'b11,  0,  7, 32'hDEAD_BEEF, 32'hA,       2'b11,  0,  5, 32'h0,        32'h2222_2222);
    tbl[4]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b11,  0,  7, 32'h0,        32'hA);
    tbl[5]  = mk(2'b01,  7,  0, 32'hB,        32'h0,        2'b11,  7,  5, SAME7,        32'h2222_2222);
    tbl[6]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b01,  7,  5, 32'hB,        32'h2222_2222);
    tbl[7]  = mk(2'b10,  0,  3, 32'h0,        32'h55,       2'b10,  7,  0, 32'hB,        32'h0);
    tbl[8]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b01,  3,  3, 32'h55,       32'h0);
    tbl[9]  = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b10,  3,  3, 32'h55,       32'h55);
    tbl[10] = mk(2'b11, 12, 12, 32'h1212,     32'h3434,     2'b01, 12,  3, SAME12,       32'h55);
    tbl[11] = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b11, 12, 12, 32'h3434,     32'h3434);
    tbl[12] = mk(2'b11, 31, 30, 32'hFFFF_FFFF, 32'h8000_0001, 2'b00, 31, 30, 32'h3434,   32'h3434);
    tbl[13] = mk(2'b00,  0,  0, 32'h0,        32'h0,        2'b11, 31, 30, 32'hFFFF_FFFF, 32'h8000_0001);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", {31'd0, ready}, 32'h0);
    check("rst state", {31'd0, state}, 32'h0);
    check("rst rdata0", rdata[31:0], 32'h0);
    check("rst rdata1", rdata[63:32], 32'h0);
    rst = 1'b0;
    clear_sweep("init");

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      drive_write(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1);
      drive_read(tbl[i].re, tbl[i].ra0, tbl[i].ra1);
      step();
      check($sformatf("vec%0d p0", i), rdata[31:0], tbl[i].exp0);
      check($sformatf("vec%0d p1", i), rdata[63:32], tbl[i].exp1);
    end
    idle_inputs();

    // Hold then clr: a write during the clear is dropped, addr 3 reads 0 after
    drive_read(2'b01, 3, 0);
    step();
    check("hold read", rdata[31:0], 32'h55);
    drive_read(2'b00, 3, 0);
    step();
    check("hold idle", rdata[31:0], 32'h55);
    clr = 1'b1;
    drive_write(2'b01, 3, 0, 32'h77, 32'h0);
    step();
    check("clr ready", {31'd0, ready}, 32'h0);
    check("clr edge hold", rdata[31:0], 32'h55);
    clr = 1'b0;
    drive_write(2'b00, 0, 0, 32'h0, 32'h0);
    for (int e = 1; e <= 31; e++) begin
      if (e == 10) begin
        drive_write(2'b01, 3, 0, 32'h99, 32'h0);
        drive_read(2'b01, 3, 0);
      end else begin
        drive_write(2'b00, 0, 0, 32'h0, 32'h0);
        drive_read(2'b00, 3, 0);
      end
      step();
      check($sformatf("clr ready e%0d", e), {31'd0, ready}, {31'd0, (e == 31)});
      check($sformatf("clr rdata0 e%0d", e), rdata[31:0], 32'h0);
    end
    idle_inputs();
    drive_read(2'b11, 3, 31);
    step();
    check("after clr addr3", rdata[31:0], 32'h0);
    check("after clr addr31", rdata[63:32], 32'h0);

    // clr during clear restarts the sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (4) step();
    check("restart mid ready", {31'd0, ready}, 32'h0);
    clr = 1'b1;
    step();
    check("restart edge ready", {31'd0, ready}, 32'h0);
    clr = 1'b0;
    clear_sweep("restart");

    // Populate an entry so the later clear has something to zero
    drive_write(2'b01, 31, 0, 32'hCAFE_0001, 32'h0);
    drive_read(2'b00, 0, 0);
    step();
    drive_write(2'b00, 0, 0, 32'h0, 32'h0);
    drive_read(2'b01, 31, 0);
    step();
    check("pre-rst addr31", rdata[31:0], 32'hCAFE_0001);

    // Mid-clear reset: reset, run 10 clear edges, reset again, full sweep
    idle_inputs();
    rst = 1'b1;
    #2;
    check("async rst rdata0", rdata[31:0], 32'h0);
    check("async rst ready", {31'd0, ready}, 32'h0);
    rst = 1'b0;
    repeat (10) step();
    check("mid clear ready", {31'd0, ready}, 32'h0);
    rst = 1'b1;
    #2;
    check("mid rst state", {31'd0, state}, 32'h0);
    rst = 1'b0;
    clear_sweep("midrst");
    drive_read(2'b11, 31, 5);
    step();
    check("final addr31", rdata[31:0], 32'h0);
    check("final addr5", rdata[63:32], 32'h0);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the tinyMIPS core and its dual-issue successor. It replaces the fixed 32×32, two-read/one-write register file. New capabilities:
- configurable data width, depth and read/write port counts;
- write-port priority;
- hold-on-idle read outputs;
- a sequenced clear engine that zeroes the array after reset or on request, without a per-entry reset, so the array maps to RAM.

It sits between the ID stage (read ports) and the WB stage(s) (write ports).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W entries
- `NUM_RD`, 2, read ports, 1..4
- `NUM_WR`, 2, write ports, 1..2
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: asynchronous, active-high reset
- `clr` input 1: request a full array clear, sampled on clk
- `ready` output 1: high when the array is usable; low while clearing
- `we` input NUM_WR: per-port write enable
- `waddr` input NUM_WR*ADDR_W: packed write addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `wdata` input NUM_WR*DATA_W: packed write data
- `re` input NUM_RD: per-port read enable
- `raddr` input NUM_RD*ADDR_W: packed read addresses
- `rdata` output NUM_RD*DATA_W: packed registered read data

## Operation
- **Entry 0:** hardwired zero. Writes to address 0 are discarded, and reads of address 0 return 0.
- **States:** CLEAR and READY.
  - `rst` forces state = CLEAR, clear counter = 1, ready = 0 and all rdata = 0.
- **CLEAR state:**
  - Each edge writes 0 to entry[counter], then increments the counter.
  - On the edge that clears entry 2^ADDR_W−1, the block moves to READY and ready goes to 1.
  - All we are ignored.
  - Reads return 0 regardless of re.
- **READY state:**
  - `clr`=1 on an edge sends the block to CLEAR with counter = 1 and ready = 0. Writes on that edge are ignored.
  - `clr`=1 during CLEAR restarts the counter at 1.
- **Writes:** on each edge in READY, every port with we=1 and waddr≠0 writes wdata. If two ports target the same address, the higher-index port wins.
- **Reads, per port, in READY, in priority order:**
  1. raddr=0 → 0.
  2. re=0 → rdata holds its previous value.
  3. re=1 → array contents, subject to the bypass rule in Configuration.
- **Width rule:** data is stored unmodified; there are no sign or zero extensions.

## Timing
- **Read latency:** 1 cycle. raddr/re sampled at edge N produce rdata after edge N.
- **Write visibility:**
  - Written at edge N, the value is visible in array reads sampled at edge N+1.
  - A read at the same edge N depends on configuration.
- **Clear duration:** 2^ADDR_W−1 edges after rst deasserts (31 for the default). ready rises after edge 31, and writes are accepted from edge 32.
- **clr latency:** ready falls after the edge that samples clr=1. The clear duration then repeats from that edge.
- **Reset mid-operation:** an asynchronous abort. A clear restarts from entry 1, and array contents are don't-care until ready=1.

## Configuration
- **`REGS_BYPASS_EN` defined:** write-to-read forwarding.
  - A read with re=1 and raddr≠0 that matches a write address with we=1 at the same edge returns that edge's wdata.
  - When both write ports hit the address, the highest-index matching write port's data is returned.
- **`REGS_BYPASS_EN` undefined:** read-before-write. The same-edge read returns the old array value, and the new value appears one cycle later.
- Port-count, width and clear behaviour are identical in both builds.

## Test plan
- **Reset and clear timing:** assert rst, release, hold all inputs 0 → ready=0 for 31 edges, 1 after edge 31; all rdata=0 throughout; reading any address afterward returns 0.
- **Dual write collision:** we=2'b11, waddr both 5, wdata0=0x1111_1111, wdata1=0x2222_2222; read addr 5 next cycle → 0x2222_2222.
- **Entry 0:** write 0xDEAD_BEEF to addr 0 → read addr 0 returns 0.
- **Same-edge read/write:** addr 7 holds 0xA; write 0xB and read addr 7 on the same edge → rdata=0xB with REGS_BYPASS_EN, 0xA without; 0xB on the following read in both builds.
- **Hold and clr:** read 0x55 from addr 3, then drop re → rdata stays 0x55. Pulse clr → ready=0 for 31 edges; a write attempted during the clear is dropped; addr 3 then reads 0.
- **Mid-clear reset:** assert rst at clear edge 10 → clear restarts; ready rises exactly 31 edges after the second release.
